div_iter: RTL and testbench
===========================

DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 32 bits.
REQ-002 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-003 Ports SHALL be, clock and reset first:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  async active-low reset.
- signed_div_i  in  1  1 = two's-complement divide, 0 = unsigned divide.
- opdata1_i  in  32  dividend.
- opdata2_i  in  32  divisor.
- start_i  in  1  request; held high by the initiator until ready_o is seen.
- annul_i  in  1  abort the operation in progress.
- result_o  out  64  {remainder[63:32], quotient[31:0]}.
- ready_o  out  1  result_o is valid.

Function
REQ-004 The block SHALL implement four states: FREE, BY_ZERO, ON and END.
REQ-005 In FREE, start_i=1 with annul_i=0 SHALL capture signed_div_i, opdata1_i and opdata2_i; the next state SHALL be BY_ZERO if opdata2_i=0, else ON.
- In FREE, all other input combinations SHALL hold FREE.
REQ-006 On FREE->ON, magnitudes SHALL be latched: |operand| when signed and the operand is negative, else the raw value. The iteration counter SHALL be cleared to 0.
REQ-007 Operand inputs SHALL be ignored after capture until the block returns to FREE.
REQ-008 In ON, each edge SHALL perform one restoring shift-subtract step.
- Partial remainder width: 33 bits.
- One quotient bit per cycle, MSB first.
- The counter increments on each step.
- After exactly 32 steps the state SHALL become END.
REQ-009 The edge that enters END from ON SHALL register sign-corrected results into result_o and set ready_o=1.
- Quotient is negated when signed and the operand signs differ.
- Remainder is negated when signed and the dividend is negative.
REQ-010 BY_ZERO SHALL go to END on the next edge with result_o=64'h0 and ready_o=1.
REQ-011 Latency: if start is sampled at edge N, ready_o SHALL rise after edge N+32 (nonzero divisor) or after edge N+1 (zero divisor).
REQ-012 In END, ready_o and result_o SHALL hold while start_i=1.
- When start_i=0 is sampled, the state SHALL return to FREE with ready_o=0 and result_o=0 on that edge.
REQ-013 annul_i=1 in ON or BY_ZERO SHALL return the state to FREE on the next edge with ready_o=0 and result_o=0. No result SHALL be produced for that request.
REQ-014 annul_i SHALL be ignored in END; an annul arriving in FREE together with start_i SHALL block acceptance of that start.
REQ-015 Deassertion of start_i in ON or BY_ZERO SHALL be ignored; only annul_i aborts.
REQ-016 Signed 0x80000000 / 0xFFFFFFFF SHALL return quotient 0x80000000 and remainder 0, with no exception or flag.
REQ-017 A new start_i SHALL be accepted on the first edge after the block has returned to FREE. Back-to-back requests therefore require start_i to be low for at least one sampled edge.
REQ-018 ready_o SHALL be 1 only in END.

Reset
REQ-019 While resetn=0, independent of clk, the outputs SHALL be:
- state = FREE
- ready_o = 0
- result_o = 64'h0
- counter = 0
- captured operands = 0
REQ-020 Reset asserted mid-operation SHALL discard the operation. After release, the block SHALL behave as freshly reset.

Verification
REQ-021 Unsigned 100/7: start edge N, signed_div_i=0 -> ready_o=1 after edge N+32; result_o={32'd2, 32'd14}; start_i dropped -> ready_o=0 next edge.
REQ-022 Signed 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / 0xFFFFFFFE (-2) -> quotient 0xFFFFFFFD, remainder 0x00000001.
REQ-023 Divisor 0 (either mode) -> ready_o=1 after edge N+1; result_o=64'h0.
REQ-024 Dividend 0x80000000, divisor 0xFFFFFFFF:
- signed -> quotient 0x80000000, remainder 0
- unsigned -> quotient 0, remainder 0x80000000
REQ-025 annul_i pulsed at step 10 of an ON sequence -> ready_o never rises; state FREE next edge. A fresh 100/7 request started afterwards returns {2, 14} with 32-cycle latency.
REQ-026 resetn driven low at step 20, asynchronously between edges -> ready_o=0 and result_o=0 immediately. After release, a 0xFFFFFFFF/0x10 unsigned request -> {32'h0000000F, 32'h0FFFFFFF}.

Source files
------------

// File: rtl/div_iter.sv
// Iterative 32-bit restoring divider, one quotient bit per clock.
// Signed operands are divided as magnitudes and the signs are restored when the result is registered.
module div_iter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    // state   | meaning
    // FREE    | idle, waiting for start_i without annul_i
    // BY_ZERO | divisor was zero, result is forced to 0
    // ON      | iterating, one shift-subtract step per edge
    // END     | result valid, held until start_i drops
    typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

    state_t      state, state_next;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [32:0] rem;
    logic [5:0]  cnt;
    logic        neg_q;
    logic        neg_r;

    logic        accept;
    logic        op1_neg, op2_neg;
    logic [31:0] mag1, mag2;
    logic [33:0] rem_shift;
    logic [32:0] diff;
    logic        q_bit;
    logic [32:0] rem_next;
    logic [31:0] dvd_next;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic        last_step;

    assign accept    = (state == FREE) && start_i && !annul_i;
    assign op1_neg   = signed_div_i && opdata1_i[31];
    assign op2_neg   = signed_div_i && opdata2_i[31];
    assign mag1      = op1_neg ? -opdata1_i : opdata1_i;
    assign mag2      = op2_neg ? -opdata2_i : opdata2_i;

    // The remainder is always below the divisor, so the shifted value never overflows 33 bits.
    assign rem_shift = {rem, dvd[31]};
    assign diff      = rem_shift[32:0] - {1'b0, dvs};
    assign q_bit     = (rem_shift >= {2'b00, dvs});
    assign rem_next  = q_bit ? diff : rem_shift[32:0];
    assign dvd_next  = {dvd[30:0], q_bit};
    assign quot_fix  = neg_q ? -dvd_next : dvd_next;
    assign rem_fix   = neg_r ? -rem_next[31:0] : rem_next[31:0];
    assign last_step = (cnt == 6'd31);

    always_comb begin
        state_next = state;
        case (state)
            FREE: begin
                if (accept) begin
                    state_next = (opdata2_i == 32'h0) ? BY_ZERO : ON;
                end
            end
            BY_ZERO: state_next = annul_i ? FREE : END;
            ON: begin
                if (annul_i) begin
                    state_next = FREE;
                end else if (last_step) begin
                    state_next = END;
                end
            end
            END: begin
                if (!start_i) begin
                    state_next = FREE;
                end
            end
            default: state_next = FREE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= FREE;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                FREE: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                    if (accept) begin
                        dvd   <= mag1;
                        dvs   <= mag2;
                        rem   <= '0;
                        cnt   <= '0;
                        neg_q <= op1_neg ^ op2_neg;
                        neg_r <= op1_neg;
                    end
                end
                BY_ZERO: begin
                    result_o <= '0;
                    ready_o  <= !annul_i;
                end
                ON: begin
                    if (annul_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end else begin
                        dvd <= dvd_next;
                        rem <= rem_next;
                        cnt <= cnt + 6'd1;
                        if (last_step) begin
                            result_o <= {rem_fix, quot_fix};
                            ready_o  <= 1'b1;
                        end
                    end
                end
                END: begin
                    if (!start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: expected results queued at start, popped when ready_o rises.
module tb_div_iter;

    logic        clk;
    logic        resetn;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    logic [63:0] sb[$];
    int          n_cmp;
    int          n_bad;

    div_iter dut (
        .clk          (clk),
        .resetn       (resetn),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb, q, r;
        if (b == 32'h0) return 64'h0;
        ma = (s && a[31]) ? -a : a;
        mb = (s && b[31]) ? -b : b;
        q  = ma / mb;
        r  = ma % mb;
        if (s && (a[31] ^ b[31])) q = -q;
        if (s && a[31]) r = -r;
        return {r, q};
    endfunction

    // Drive one request, wait bounded for ready, then check hold and release.
    task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        int n;
        int exp_lat;
        logic [63:0] want;
        sb.push_back(exp);
        exp_lat = (b == 32'h0) ? 1 : 32;
        @(negedge clk);
        signed_div = s; op1 = a; op2 = b; start = 1'b1;
        @(posedge clk);
        #1;
        op1 = $urandom; op2 = $urandom; signed_div = ~s;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (ready) break;
        end
        chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
        want = sb.pop_front();
        chk({tag, "_result"}, result, want);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_hold_ready"}, 64'(ready), 64'd1);
        chk({tag, "_hold_result"}, result, want);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_drop_ready"}, 64'(ready), 64'd0);
        chk({tag, "_drop_result"}, result, 64'h0);
    endtask

    initial begin
        int seen;
        logic [31:0] ra, rb;
        logic rs;
        n_cmp = 0; n_bad = 0;
        resetn = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0; start = 1'b0; annul = 1'b0;
        #12;
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_result", result, 64'h0);
        @(negedge clk);
        resetn = 1'b1;

        run_op("u100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
        run_op("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
        run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD});
        run_op("u_div0", 1'b0, 32'd1234, 32'd0, 64'h0);
        run_op("s_div0", 1'b1, 32'hFFFFFFFF, 32'd0, 64'h0);
        run_op("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000});
        run_op("u_ovf", 1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h0});
        run_op("u_max1", 1'b0, 32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF});
        run_op("u_small", 1'b0, 32'd5, 32'd9, {32'd5, 32'd0});

        // Annul blocks a start when asserted together.
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1; annul = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready) seen = 1;
        end
        chk("annul_blocks_start", 64'(seen), 64'd0);
        start = 1'b0; annul = 1'b0;

        // Annul at step 10; start is dropped too, which alone must not abort.
        @(negedge clk);
        op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul = 1'b1; start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        annul = 1'b0;
        chk("annul_ready", 64'(ready), 64'd0);
        chk("annul_result", result, 64'h0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready) seen = 1;
        end
        chk("annul_no_ready", 64'(seen), 64'd0);
        run_op("after_annul", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});

        // Dropping start mid-operation must not abort.
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready) seen = 1;
        end
        chk("start_drop_ignored", 64'(seen), 64'd1);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_mid_ready", 64'(ready), 64'd0);
        chk("rst_mid_result", result, 64'h0);
        start = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        run_op("after_reset", 1'b0, 32'hFFFFFFFF, 32'h10, {32'h0000000F, 32'h0FFFFFFF});

        // Asynchronous reset while a result is being held.
        @(negedge clk);
        op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        seen = 0;
        for (int i = 0; i < 100 && seen == 0; i++) begin
            @(negedge clk);
            if (ready) seen = 1;
        end
        chk("end_reached", 64'(seen), 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_end_ready", 64'(ready), 64'd0);
        chk("rst_end_result", result, 64'h0);
        start = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : ($urandom >> (i * 3));
            rs = i[0];
            run_op("rand", rs, ra, rb, model(rs, ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
